// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states and owner ids.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RSP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner select between the IFU and LSU requesters.
// Macro ARB_ROUND_ROBIN_EN: when defined, a tie goes to the requester that
// did not win last time; otherwise the LSU always wins a tie.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic   ifu_valid,
    input  logic   lsu_valid,
`ifdef ARB_ROUND_ROBIN_EN
    input  owner_t last_owner,
`endif
    output logic   grant,
    output owner_t winner
);

    assign grant = ifu_valid | lsu_valid;

    // Winner is only meaningful when grant is set; a lone requester always wins.
    always_comb begin
        winner = OWN_LSU;
`ifdef ARB_ROUND_ROBIN_EN
        if (ifu_valid && lsu_valid)
            winner = (last_owner == OWN_LSU) ? OWN_IFU : OWN_LSU;
        else if (ifu_valid)
            winner = OWN_IFU;
`else
        if (ifu_valid && !lsu_valid)
            winner = OWN_IFU;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU and LSU.
// The granted request is buffered, issued on mem_req_*, and its response is
// forwarded combinationally to the owner.
// Macro ARB_ROUND_ROBIN_EN: enables alternating tie-break via last_owner.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_rsp_valid,
    input  logic              ifu_rsp_ready,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_rsp_valid,
    input  logic              lsu_rsp_ready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_rsp_valid,
    output logic              mem_rsp_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state_q;
    owner_t            owner_q;
    owner_t            winner;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic              grant;
    logic              in_idle;
    logic              in_req;
    logic              in_rsp;
    logic              accept;
`ifdef ARB_ROUND_ROBIN_EN
    owner_t            last_owner;
`endif

    arb_pick u_pick (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
`ifdef ARB_ROUND_ROBIN_EN
        .last_owner (last_owner),
`endif
        .grant      (grant),
        .winner     (winner)
    );

    // Gating state decodes with rst keeps every handshake output low during reset.
    assign in_idle = !rst && (state_q == ARB_IDLE);
    assign in_req  = !rst && (state_q == ARB_REQ);
    assign in_rsp  = !rst && (state_q == ARB_RSP);
    assign accept  = in_idle && grant;

    assign ifu_req_ready = accept && (winner == OWN_IFU);
    assign lsu_req_ready = accept && (winner == OWN_LSU);

    assign mem_req_valid = in_req;
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    assign mem_rsp_ready = in_rsp && ((owner_q == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready);
    assign ifu_rsp_valid = in_rsp && (owner_q == OWN_IFU) && mem_rsp_valid;
    assign lsu_rsp_valid = in_rsp && (owner_q == OWN_LSU) && mem_rsp_valid;
    assign ifu_rdata     = (in_rsp && (owner_q == OWN_IFU)) ? mem_rdata : '0;
    assign lsu_rdata     = (in_rsp && (owner_q == OWN_LSU)) ? mem_rdata : '0;

    // Transaction FSM: buffer the winner at accept, hold until request and response handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (grant) begin
                        state_q <= ARB_REQ;
                        owner_q <= winner;
                        if (winner == OWN_LSU) begin
                            addr_q  <= lsu_addr;
                            wen_q   <= lsu_wen;
                            wdata_q <= lsu_wdata;
                            wmask_q <= lsu_wmask;
                        end else begin
                            addr_q  <= ifu_addr;
                            wen_q   <= 1'b0;
                            wdata_q <= '0;
                            wmask_q <= '0;
                        end
                    end
                end
                ARB_REQ: begin
                    if (mem_req_ready)
                        state_q <= ARB_RSP;
                end
                ARB_RSP: begin
                    if (mem_rsp_valid && mem_rsp_ready)
                        state_q <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember who was granted last so the next tie goes the other way.
    always_ff @(posedge clk) begin
        if (rst)
            last_owner <= OWN_IFU;
        else if (accept)
            last_owner <= winner;
    end
`endif

endmodule
